// File: rtl/input_pkg.sv
// Shared sizes and vector types for the switch/button conditioning front end.
package input_pkg;

  localparam int unsigned N_SW              = 16;
  localparam int unsigned N_BTN             = 4;
  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

  typedef logic [N_SW-1:0]  sw_vec_t;
  typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, restartable stability counter, accepted level and 0->1 pulse.
module debounce_bit
  import input_pkg::*;
#(
  parameter int unsigned DbCycles = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic rise_set_o
);

  localparam int unsigned CntW = (DbCycles > 2) ? $clog2(DbCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DbCycles - 1);

  logic            s1_q, s2_q;
  logic            stb_q, stb_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any return of s2 to the accepted level restarts the count.
  always_comb begin
    stb_d  = stb_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (s2_q != stb_q) begin
      if (cnt_q == CntMax) begin
        stb_d  = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      stb_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      stb_q  <= stb_d;
      rise_q <= rise_d;
    end
  end

  assign level_o    = stb_q;
  assign rise_o     = rise_q;
  // Fires on the edge that will raise rise_o, so callers can act in the same cycle.
  assign rise_set_o = rise_d;

endmodule

// File: rtl/input_debouncer.sv
// Debounces switches and buttons; INPUT_DEBOUNCER_STICKY_EN adds write-1-to-clear press flags.
module input_debouncer
  import input_pkg::*;
#(
  parameter int unsigned N_SW      = input_pkg::N_SW,
  parameter int unsigned N_BTN     = input_pkg::N_BTN,
  parameter int unsigned DB_CYCLES = input_pkg::DB_CYCLES_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SW-1:0]  sw_raw_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_SW-1:0]  sw_o,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_rise_o,
  input  logic [N_BTN-1:0] evt_clr_i,
  output logic [N_BTN-1:0] btn_evt_o
);

  logic [N_SW-1:0]  unused_sw_rise;
  logic [N_SW-1:0]  unused_sw_rise_set;
  logic [N_BTN-1:0] btn_rise_set;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DbCycles(DB_CYCLES)
    ) u_db (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .raw_i     (sw_raw_i[i]),
      .level_o   (sw_o[i]),
      .rise_o    (unused_sw_rise[i]),
      .rise_set_o(unused_sw_rise_set[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DbCycles(DB_CYCLES)
    ) u_db (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .raw_i     (btn_raw_i[i]),
      .level_o   (btn_o[i]),
      .rise_o    (btn_rise_o[i]),
      .rise_set_o(btn_rise_set[i])
    );
  end

`ifdef INPUT_DEBOUNCER_STICKY_EN
  logic [N_BTN-1:0] evt_q, evt_d;

  // A rise on the same edge as a clear keeps the flag set.
  always_comb begin
    evt_d = btn_rise_set | (evt_q & ~evt_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign btn_evt_o = evt_q;
`else
  logic [N_BTN-1:0] unused_evt_clr;
  logic [N_BTN-1:0] unused_btn_rise_set;

  assign unused_evt_clr      = evt_clr_i;
  assign unused_btn_rise_set = btn_rise_set;
  assign btn_evt_o           = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (DB_CYCLES=4): directed scenarios plus random stimulus vs a window model.
module tb_input_debouncer;

  localparam int unsigned Db = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] sw_raw_i;
  logic [3:0]  btn_raw_i;
  logic [3:0]  evt_clr_i;
  logic [15:0] sw_o;
  logic [3:0]  btn_o;
  logic [3:0]  btn_rise_o;
  logic [3:0]  btn_evt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last Db+2 pin samples, accepted levels, pulses and flags.
  logic [19:0] hist [Db+2];
  logic [19:0] m_lvl;
  logic [3:0]  m_rise;
  logic [3:0]  m_evt;

  input_debouncer #(
    .N_SW     (16),
    .N_BTN    (4),
    .DB_CYCLES(Db)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sw_raw_i  (sw_raw_i),
    .btn_raw_i (btn_raw_i),
    .sw_o      (sw_o),
    .btn_o     (btn_o),
    .btn_rise_o(btn_rise_o),
    .evt_clr_i (evt_clr_i),
    .btn_evt_o (btn_evt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < Db + 2; j++) hist[j] = '0;
    m_lvl  = '0;
    m_rise = '0;
    m_evt  = '0;
  endtask

  // A bit's level flips once the synchronised value (pin two edges ago) has
  // differed from it for Db consecutive edges.
  task automatic model_edge();
    logic [3:0] new_rise;
    logic       all_diff;
    if (!rst_ni) begin
      model_reset();
    end else begin
      for (int j = Db + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0]  = {btn_raw_i, sw_raw_i};
      new_rise = '0;
      for (int b = 0; b < 20; b++) begin
        all_diff = 1'b1;
        for (int j = 2; j < Db + 2; j++) if (hist[j][b] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b] = ~m_lvl[b];
          if (b >= 16 && m_lvl[b]) new_rise[b-16] = 1'b1;
        end
      end
      m_rise = new_rise;
      m_evt  = new_rise | (m_evt & ~evt_clr_i);
    end
  endtask

  task automatic check_all();
    check_eq("sw_o", {16'h0, sw_o}, {16'h0, m_lvl[15:0]});
    check_eq("btn_o", {28'h0, btn_o}, {28'h0, m_lvl[19:16]});
    check_eq("btn_rise_o", {28'h0, btn_rise_o}, {28'h0, m_rise});
`ifdef INPUT_DEBOUNCER_STICKY_EN
    check_eq("btn_evt_o", {28'h0, btn_evt_o}, {28'h0, m_evt});
`else
    check_eq("btn_evt_o", {28'h0, btn_evt_o}, 32'h0);
`endif
  endtask

  // Called at a negedge; returns at the next negedge with inputs free to change.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
    @(negedge clk_i);
  endtask

  task automatic assert_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  int          pulses;
  logic [19:0] vec;
  int unsigned hold;

  initial begin
    rst_ni    = 1'b0;
    sw_raw_i  = 16'hFFFF;
    btn_raw_i = '0;
    evt_clr_i = '0;
    model_reset();
    @(negedge clk_i);

    // Reset with all switches high, then exact acceptance latency.
    for (int i = 0; i < 3; i++) step();
    rst_ni = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_eq("rst_latency_sw", {16'h0, sw_o}, (i >= 6) ? 32'hFFFF : 32'h0);
    end

    // Clean press on btn0.
    btn_raw_i[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_eq("press_btn0", {31'h0, btn_o[0]}, {31'h0, i >= 6});
      check_eq("press_rise0", {31'h0, btn_rise_o[0]}, {31'h0, i == 6});
    end

    // Bounce on btn1: 3-cycle plateaus 1,0 then held 1.
    pulses = 0;
    btn_raw_i[1] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    btn_raw_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    btn_raw_i[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      pulses += int'(btn_rise_o[1]);
      check_eq("bounce_btn1", {31'h0, btn_o[1]}, {31'h0, i >= 6});
    end
    check_eq("bounce_pulses", pulses, 1);

    // Short glitch on sw5 (sw currently all high, so drop it low briefly).
    sw_raw_i[5] = 1'b0;
    for (int i = 0; i < Db - 1; i++) step();
    sw_raw_i[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("glitch_sw5", {31'h0, sw_o[5]}, 32'h1);
    end

    // Sticky flag on btn2: set, survive release, clear, then clear vs rise.
    btn_raw_i[2] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    btn_raw_i[2] = 1'b0;
    for (int i = 0; i < 8; i++) step();
`ifdef INPUT_DEBOUNCER_STICKY_EN
    check_eq("sticky_hold", {31'h0, btn_evt_o[2]}, 32'h1);
`endif
    evt_clr_i[2] = 1'b1;
    step();
    evt_clr_i[2] = 1'b0;
    check_eq("sticky_clear", {31'h0, btn_evt_o[2]}, 32'h0);
    btn_raw_i[2] = 1'b1;
    evt_clr_i[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
`ifdef INPUT_DEBOUNCER_STICKY_EN
      check_eq("sticky_set_wins", {31'h0, btn_evt_o[2]}, {31'h0, i == 6});
`endif
    end
    evt_clr_i = '0;

    // Mid-count reset on btn3 (count at 3 after five edges).
    btn_raw_i = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    btn_raw_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    assert_reset();
    check_eq("midrst_btn", {28'h0, btn_o}, 32'h0);
    @(negedge clk_i);
    step();
    rst_ni = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_eq("midrst_latency", {31'h0, btn_o[3]}, {31'h0, i >= 6});
    end

    // Random phases: sparse bit flips held for 1..8 cycles, random clears and resets.
    for (int p = 0; p < 400; p++) begin
      vec = {btn_raw_i, sw_raw_i} ^ (20'($urandom) & 20'($urandom) & 20'($urandom));
      {btn_raw_i, sw_raw_i} = vec;
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) begin
        assert_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
      for (int c = 0; c < int'(hold); c++) begin
        evt_clr_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
